// File: rtl/pwm_pkg.sv
// Shared PWM types and default sizing.
//   PWM_N_DEFAULT  : default counter/period/duty width in bits
//   PWM_CH_DEFAULT : default number of channels
//   pwm_mode_e     : counter alignment mode
//   pwm_dir_e      : center-mode count direction
package pwm_pkg;

  localparam int unsigned PWM_N_DEFAULT  = 16;
  localparam int unsigned PWM_CH_DEFAULT = 4;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } pwm_dir_e;

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: active duty register, unsigned compare and output flop.
//   clk_i        : clock, rising edge
//   resetn_i     : synchronous active-low reset
//   enable_i     : gates the output low when 0
//   apply_i      : boundary copy strobe, duty_stage_i becomes active
//   duty_stage_i : staged duty value
//   cnt_i        : shared period counter
//   pwm_o        : registered PWM output
module pwm_chan #(
  parameter int unsigned N = pwm_pkg::PWM_N_DEFAULT
) (
  input  logic         clk_i,
  input  logic         resetn_i,
  input  logic         enable_i,
  input  logic         apply_i,
  input  logic [N-1:0] duty_stage_i,
  input  logic [N-1:0] cnt_i,
  output logic         pwm_o
);

  logic [N-1:0] duty_q;
  logic [N-1:0] duty_eff_c;

  // The boundary cycle already belongs to the new period, so it compares
  // against the value being made active rather than the outgoing one.
  assign duty_eff_c = apply_i ? duty_stage_i : duty_q;

  // Active duty register and output flop.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      duty_q <= '0;
      pwm_o  <= 1'b0;
    end else begin
      if (apply_i) begin
        duty_q <= duty_stage_i;
      end
      pwm_o <= enable_i && (cnt_i < duty_eff_c);
    end
  end

endmodule

// File: rtl/pwm_multi_n.sv
// Multi-channel PWM generator with shared edge/center-aligned counter and
// boundary-synchronised double-buffered period, mode and duty.
//   clk_i          : clock, rising edge
//   resetn_i       : synchronous active-low reset
//   enable_i       : run counter when 1, hold at 0 and drive outputs low when 0
//   load_i         : capture period_i/mode_i/duty_i into staging
//   period_i       : period value P
//   mode_i         : 0 edge-aligned, 1 center-aligned
//   duty_i         : channel k duty in bits [k*N +: N]
//   pwm_o          : registered PWM outputs
//   period_start_o : one-cycle pulse after each period boundary
//   load_ack_o     : one-cycle pulse after staged values become active
module pwm_multi_n
  import pwm_pkg::*;
#(
  parameter int unsigned N  = PWM_N_DEFAULT,
  parameter int unsigned CH = PWM_CH_DEFAULT
) (
  input  logic          clk_i,
  input  logic          resetn_i,
  input  logic          enable_i,
  input  logic          load_i,
  input  logic [N-1:0]  period_i,
  input  logic          mode_i,
  input  logic [CH*N-1:0] duty_i,
  output logic [CH-1:0] pwm_o,
  output logic          period_start_o,
  output logic          load_ack_o
);

  // Counter state.
  logic [N-1:0] cnt_q, cnt_d;
  pwm_dir_e     dir_q, dir_d;

  // Staging and active configuration.
  logic [N-1:0]   stg_period_q;
  pwm_mode_e      stg_mode_q;
  logic [CH*N-1:0] stg_duty_q;
  logic           pending_q;
  logic [N-1:0]   act_period_q;
  pwm_mode_e      act_mode_q;

  logic         boundary_c;
  logic         apply_c;
  logic [N-1:0] eff_period_c;
  pwm_mode_e    eff_mode_c;

  // A disabled cycle is always a boundary, so pending loads apply while idle.
  assign boundary_c   = !enable_i || (cnt_q == '0);
  assign apply_c      = boundary_c && pending_q;
  assign eff_period_c = apply_c ? stg_period_q : act_period_q;
  assign eff_mode_c   = apply_c ? stg_mode_q : act_mode_q;

  // Counter/direction state register.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      cnt_q <= '0;
      dir_q <= DIR_UP;
    end else begin
      cnt_q <= cnt_d;
      dir_q <= dir_d;
    end
  end

  // Counter next-state: edge wraps at P, center reflects at P and at 1.
  always_comb begin
    cnt_d = cnt_q;
    dir_d = dir_q;
    if (!enable_i) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (eff_mode_c == PWM_EDGE) begin
      dir_d = DIR_UP;
      cnt_d = (cnt_q >= eff_period_c) ? '0 : cnt_q + N'(1);
    end else if (eff_period_c == '0) begin
      cnt_d = '0;
      dir_d = DIR_UP;
    end else if (dir_q == DIR_UP || apply_c) begin
      // A freshly applied configuration always starts counting up from 0.
      if (cnt_q >= eff_period_c) begin
        if (eff_period_c == N'(1)) begin
          cnt_d = '0;
          dir_d = DIR_UP;
        end else begin
          cnt_d = eff_period_c - N'(1);
          dir_d = DIR_DOWN;
        end
      end else begin
        cnt_d = cnt_q + N'(1);
        dir_d = DIR_UP;
      end
    end else begin
      if (cnt_q <= N'(1)) begin
        cnt_d = '0;
        dir_d = DIR_UP;
      end else begin
        cnt_d = cnt_q - N'(1);
        dir_d = DIR_DOWN;
      end
    end
  end

  // Staging, pending flag, active period/mode and status pulses.
  always_ff @(posedge clk_i) begin
    if (!resetn_i) begin
      stg_period_q   <= '0;
      stg_mode_q     <= PWM_EDGE;
      stg_duty_q     <= '0;
      pending_q      <= 1'b0;
      act_period_q   <= '0;
      act_mode_q     <= PWM_EDGE;
      period_start_o <= 1'b0;
      load_ack_o     <= 1'b0;
    end else begin
      if (apply_c) begin
        act_period_q <= stg_period_q;
        act_mode_q   <= stg_mode_q;
      end
      // A load in the apply cycle overwrites staging only after the copy.
      if (load_i) begin
        stg_period_q <= period_i;
        stg_mode_q   <= pwm_mode_e'(mode_i);
        stg_duty_q   <= duty_i;
        pending_q    <= 1'b1;
      end else if (apply_c) begin
        pending_q <= 1'b0;
      end
      period_start_o <= enable_i && (cnt_q == '0);
      load_ack_o     <= apply_c;
    end
  end

  // Per-channel duty register, compare and output flop.
  for (genvar k = 0; k < int'(CH); k++) begin : g_chan
    pwm_chan #(
      .N (N)
    ) u_chan (
      .clk_i        (clk_i),
      .resetn_i     (resetn_i),
      .enable_i     (enable_i),
      .apply_i      (apply_c),
      .duty_stage_i (stg_duty_q[k*N +: N]),
      .cnt_i        (cnt_q),
      .pwm_o        (pwm_o[k])
    );
  end

endmodule

// File: doc/pwm_multi_n.md
PWM_MULTI_N -- requirements
Module: pwm_multi_n

Interface
REQ-001 SHALL have parameter N, default 16: counter, period and duty width in bits.
REQ-002 SHALL have parameter CH, default 4: number of PWM channels, range 1..32.
REQ-003 clk_i  input  1  sole clock; all logic on its rising edge.
REQ-004 resetn_i  input  1  synchronous active-low reset.
REQ-005 enable_i  input  1  run counter when 1; when 0, hold counter at 0 and drive outputs low.
REQ-006 load_i  input  1  single-cycle strobe that captures period_i, mode_i and duty_i into the staging registers.
REQ-007 period_i  input  N  period value P.
REQ-008 mode_i  input  1  0 = edge-aligned, 1 = center-aligned.
REQ-009 duty_i  input  CH*N  channel k duty D[k] in bits [k*N +: N].
REQ-010 pwm_o  output  CH  registered PWM outputs.
REQ-011 period_start_o  output  1  one-cycle pulse at each period boundary.
REQ-012 load_ack_o  output  1  one-cycle pulse when staged values become active.

Function
REQ-013 Edge mode SHALL count 0,1,..,P then wrap to 0; period length is P+1 cycles.
REQ-014 Center mode with P>=1 SHALL count up 0..P, then down P-1..1, then repeat; period length is 2P cycles.
REQ-015 Center mode with P=0 SHALL hold the counter at 0; every cycle is a boundary.
REQ-016 A boundary SHALL be any cycle in which the counter value is 0, including every cycle while enable_i=0.
REQ-017 pwm_o[k] SHALL register (enable_i && cnt < D_active[k]), giving 1-cycle latency from counter to output.
REQ-018 Duty rules: D=0 gives constant low; D>P gives constant high in both modes.
REQ-019 Compare SHALL be unsigned N-bit; the counter SHALL never exceed P_active; no overflow at P=2**N-1.
REQ-020 load_i SHALL write the staging registers and set the pending flag.
REQ-021 At a boundary with pending=1, the module SHALL copy staging into the active P, mode and D registers, clear pending, and pulse load_ack_o the next cycle.
REQ-022 If load_i coincides with a boundary, the previous staging values SHALL apply now; the new values SHALL stay pending until the next boundary.
REQ-023 Active values SHALL never change mid-period, so period and duty are glitch-free.
REQ-024 period_start_o SHALL pulse the cycle after a boundary, only while enable_i=1.
REQ-025 On a mode change at a boundary, the counter SHALL start from 0 counting up.
REQ-026 Deasserting enable_i mid-period SHALL force the counter to 0 and direction to up on the next edge; pwm_o SHALL go low one cycle later.

Reset
REQ-027 When resetn_i=0 at a clock edge, the following SHALL be cleared to 0: counter, direction (up), active registers, staging registers, pending, pwm_o, period_start_o and load_ack_o.
REQ-028 Reset SHALL take priority over load_i and enable_i.
REQ-029 Reset mid-period SHALL discard any pending load.
REQ-030 The first period after reset SHALL use P=0 and D=0, so outputs stay low until a load is applied.

Structure
REQ-031 The shared package pwm_pkg SHALL hold typedef enum pwm_mode_e {PWM_EDGE, PWM_CENTER} and the default N and CH constants.
REQ-032 The counter, direction, boundary and load control SHALL live in pwm_multi_n.
REQ-033 Each channel SHALL be an instance of sub-module pwm_chan (active duty register plus compare plus output flop), generated CH times.

Verification
REQ-034 Edge duty: N=8, P=9, D0=3, D1=0, D2=10 -> pwm_o[0] high 3 of every 10 cycles; pwm_o[1] always low; pwm_o[2] always high; period_start_o every 10 cycles.
REQ-035 Center duty: P=4, D0=2 -> count sequence 0,1,2,3,4,3,2,1; pwm_o[0] high 3 of 8 cycles, symmetric about cnt=4; period_start_o every 8 cycles.
REQ-036 Deferred load: load at cnt=5 with P=9 changing D0 3->6 -> no change until the next boundary; load_ack_o pulses once; the following period is high for 6 cycles.
REQ-037 Coincident load: load_i asserted in the boundary cycle -> new values active one full period later; exactly one load_ack_o pulse per applied load.
REQ-038 Reset and disable: resetn_i=0 at cnt=4 -> all outputs 0 next cycle, pending cleared; enable_i=0 mid-period -> counter 0, pwm_o low, no period_start_o pulses.
REQ-039 Max period: N=4, P=15, D=15 -> high 15 of 16 cycles, counter wraps 15->0 with no overflow.
